alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Multi-byte arithmetic sequencer for the mos6502 datapath.
- Accepts one NBYTES-wide operation over a valid/ready handshake and runs it one byte per cycle through a single instance of the 8-bit alu, LSB first, chaining carry/borrow between bytes.
- Holds the result until downstream accepts it.
- Serves PC/address arithmetic (16-bit increment, offset add/sub) without widening the ALU.

Parameters:
- NBYTES, 2, operand/result width in bytes; legal range 1..4. W = 8*NBYTES.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- op  input  op_seq_t (2)  SNOP, SINC, SADD, SSUB.
- a_in  input  W  operand A.
- b_in  input  W  operand B; ignored for SNOP/SINC.
- c_in  input  1  carry-in for SADD, borrow-in for SSUB, pass-through for SNOP; ignored for SINC.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- result  output  W  result.
- c_out  output  1  final carry (SADD/SINC) or borrow (SSUB); equals c_in for SNOP.

Behaviour:
- Reset values (while rst_n low): state IDLE, in_ready 0, out_valid 0, result 0, c_out 0, byte counter 0.
  - in_ready rises on the first clk edge after rst_n deasserts.
- All outputs are registered.
- States:
  - IDLE: in_ready=1. On in_valid & in_ready, latch op, a_in, b_in and the initial carry, clear counter, go RUN. in_ready drops on the same edge.
  - RUN: drive alu with byte[cnt] of A and B and the carry register.
    - Each cycle, write the alu out into result byte[cnt] and alu c_out into the carry register; cnt++.
    - When cnt==NBYTES-1, go DONE and set out_valid and c_out.
  - DONE: out_valid=1, result/c_out stable. On out_ready, clear out_valid and go IDLE (in_ready=1 next cycle).
- Latency: out_valid high exactly NBYTES+1 cycles after the accepting edge. Minimum initiation interval is NBYTES+2 cycles.
- Opcode mapping to alu func, per byte:
  - SNOP -> ANOP; initial carry = c_in; the carry passes through unchanged.
  - SADD -> AADD; initial carry = c_in.
  - SSUB -> ASUB; initial carry = c_in. Carry is borrow: 1 means borrow.
  - SINC -> AADD with B byte forced to 0 and initial carry = 1. AINC is never used, because it does not produce c_out.
- Wrap-around: results are modulo 2^W, and c_out reports the overflow/borrow. SINC of all-ones gives 0 with c_out=1.
- Operand capture: inputs may change freely after acceptance, since only the latched copies are used.
- in_valid while busy: not accepted and not queued. The requester must hold it.
- out_ready high outside DONE: ignored.
- Reset mid-operation (RUN or DONE): aborts immediately. The partial result is discarded and all outputs return to their reset values.

Optional Feature:
- Macro: ALU_SEQ_FLAGS_EN.
- Defined: adds output ports z_out, n_out, v_out (1 bit each, registered, reset 0, valid with out_valid).
  - z_out = (result==0).
  - n_out = result[W-1].
  - v_out = signed overflow of the full-width SADD/SSUB/SINC, computed from operand and result MSBs.
  - For SNOP, v_out=0.
- Undefined: these ports and their logic do not exist. All other behaviour is identical.

Decomposition:
- common_types package:
  - add enum op_seq_t {SNOP, SINC, SADD, SSUB} (2 bits);
  - add localparam SEQ_MAX_BYTES=4;
  - reuse data_t and alu_t.
- The state enum {IDLE, RUN, DONE} stays local to the module.
- One sub-module: the existing alu, instantiated once. Byte select and carry register live in alu_seq.

Test Plan:
- SADD, NBYTES=2: A=0x12FF, B=0x0001, c_in=0 -> result 0x1300, c_out 0; out_valid exactly 3 cycles after accept.
- SSUB: A=0x0000, B=0x0001, c_in=0 -> result 0xFFFF, c_out 1. A=0x1000, B=0x0001 -> 0x0FFF, c_out 0.
- SINC: A=0xFFFF, b_in=0xAAAA (ignored) -> result 0x0000, c_out 1. SNOP: A=0xBEEF, c_in=1 -> 0xBEEF, c_out 1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result/c_out stable, out_valid 1, in_ready 0. A new in_valid is not accepted until the cycle after the out_ready handshake.
- Reset mid-RUN: assert rst_n=0 asynchronously between clk edges -> out_valid/result/c_out 0 immediately. After release, in_ready=1 on the first edge and the next request computes correctly.
- ALU_SEQ_FLAGS_EN: SADD 0x7FFF+0x0001 -> result 0x8000, n=1, v=1, z=0. SSUB 0x0005-0x0005 -> z=1, c_out 0.

Source files
------------

// File: rtl/common_types.sv
// Shared types for the mos6502 datapath.
//   data_t        : one datapath byte
//   alu_t         : 8-bit alu function select
//   op_seq_t      : multi-byte sequencer operation (alu_seq)
//   SEQ_MAX_BYTES : widest operand alu_seq is meant to handle
//   seq_func()    : per-byte alu function used for each sequencer op
package common_types;

  typedef logic [7:0] data_t;

  typedef enum logic [1:0] {
    ANOP,
    AADD,
    ASUB,
    AINC
  } alu_t;

  typedef enum logic [1:0] {
    SNOP,
    SINC,
    SADD,
    SSUB
  } op_seq_t;

  localparam int SEQ_MAX_BYTES = 4;

  // SINC runs as AADD (B forced to 0, carry-in 1) because AINC gives no carry-out.
  function automatic alu_t seq_func(input op_seq_t op);
    case (op)
      SNOP:    return ANOP;
      SINC:    return AADD;
      SADD:    return AADD;
      SSUB:    return ASUB;
      default: return ANOP;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// 8-bit combinational alu of the mos6502 datapath.
// Ports:
//   a, b  : operand bytes
//   c_in  : carry-in (AADD), borrow-in (ASUB), passed through (ANOP)
//   func  : function select (alu_t)
//   y     : result byte
//   c_out : carry-out (AADD), borrow-out (ASUB), c_in (ANOP), 0 (AINC)
module alu
  import common_types::*;
(
  input  data_t a,
  input  data_t b,
  input  logic  c_in,
  input  alu_t  func,
  output data_t y,
  output logic  c_out
);

  logic [8:0] wide;

  always_comb begin
    wide  = '0;
    y     = a;
    c_out = c_in;
    case (func)
      AADD: begin
        wide  = {1'b0, a} + {1'b0, b} + {8'b0, c_in};
        y     = wide[7:0];
        c_out = wide[8];
      end
      ASUB: begin
        // A 9-bit difference that goes negative sets bit 8: that is the borrow.
        wide  = {1'b0, a} - {1'b0, b} - {8'b0, c_in};
        y     = wide[7:0];
        c_out = wide[8];
      end
      AINC: begin
        y     = a + 8'd1;
        c_out = 1'b0;
      end
      default: begin
        y     = a;
        c_out = c_in;
      end
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-byte arithmetic sequencer: runs one NBYTES-wide SNOP/SINC/SADD/SSUB
// through a single 8-bit alu, one byte per cycle, LSB first, chaining the
// carry/borrow, and holds the result until the consumer takes it.
// Optional flag outputs are enabled with the macro ALU_SEQ_FLAGS_EN.
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready  : request handshake
//   op, a_in, b_in, c_in: operation, operands, carry/borrow-in
//   out_valid, out_ready: result handshake
//   result, c_out       : W-bit result and final carry/borrow
//   z_out, n_out, v_out : zero / negative / signed-overflow (ALU_SEQ_FLAGS_EN only)
module alu_seq
  import common_types::*;
#(
  parameter  int NBYTES = 2,  // 1..SEQ_MAX_BYTES
  localparam int W      = 8 * NBYTES
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  op_seq_t       op,
  input  logic [W-1:0]  a_in,
  input  logic [W-1:0]  b_in,
  input  logic          c_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  result,
  output logic          c_out
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic          z_out,
  output logic          n_out,
  output logic          v_out
`endif
);

  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt;
  logic [NBYTES-1:0][7:0]  a_q, b_q, res_q, res_nxt;
  alu_t                    func_q;
  logic                    carry;
  data_t                   alu_y;
  logic                    alu_c;
  logic                    accept, step, last, done_ack;

  alu u_alu (
    .a     (a_q[cnt]),
    .b     (b_q[cnt]),
    .c_in  (carry),
    .func  (func_q),
    .y     (alu_y),
    .c_out (alu_c)
  );

  assign result = res_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Control decode
  always_comb begin
    accept   = (state == IDLE) && in_valid && in_ready;
    step     = (state == RUN);
    last     = step && (cnt == CW'(NBYTES - 1));
    done_ack = (state == DONE) && out_ready;
  end

  // Result with the current alu byte merged in; what res_q becomes on a step.
  always_comb begin
    res_nxt      = res_q;
    res_nxt[cnt] = alu_y;
  end

  // Operand capture: only the latched copies feed the alu.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q    <= a_in;
      b_q    <= (op == SINC) ? '0 : b_in;
      func_q <= seq_func(op);
    end
  end

  // Sequencing and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      res_q     <= '0;
      c_out     <= 1'b0;
      cnt       <= '0;
      carry     <= 1'b0;
    end else begin
      // in_ready is 0 straight out of reset and rises on the first edge in IDLE.
      if (accept)                in_ready <= 1'b0;
      else if (state == IDLE)    in_ready <= 1'b1;
      else if (done_ack)         in_ready <= 1'b1;

      if (accept) begin
        cnt   <= '0;
        carry <= (op == SINC) ? 1'b1 : c_in;
      end else if (step) begin
        res_q <= res_nxt;
        carry <= alu_c;
        cnt   <= last ? '0 : cnt + CW'(1);
      end

      if (last) begin
        out_valid <= 1'b1;
        c_out     <= alu_c;
      end else if (done_ack) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic a_msb, b_msb, r_msb, v_nxt;

  // Signed overflow from the MSBs; b_q is already 0 for SINC, so AADD covers it.
  always_comb begin
    a_msb = a_q[NBYTES-1][7];
    b_msb = b_q[NBYTES-1][7];
    r_msb = res_nxt[NBYTES-1][7];
    case (func_q)
      AADD:    v_nxt = (a_msb == b_msb) && (r_msb != a_msb);
      ASUB:    v_nxt = (a_msb != b_msb) && (r_msb != a_msb);
      default: v_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_out <= 1'b0;
      n_out <= 1'b0;
      v_out <= 1'b0;
    end else if (last) begin
      z_out <= (res_nxt == '0);
      n_out <= r_msb;
      v_out <= v_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (NBYTES=2). Compile with +define+ALU_SEQ_FLAGS_EN
// to include the flag outputs and their checks.
module tb_alu_seq;
  import common_types::*;

  localparam int NBYTES = 2;
  localparam int W      = 8 * NBYTES;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  op_seq_t       op;
  logic [W-1:0]  a_in, b_in;
  logic          c_in;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          c_out;
`ifdef ALU_SEQ_FLAGS_EN
  logic          z_out, n_out, v_out;
  logic [2:0]    cap_flags;
`endif

  int tests = 0;
  int fails = 0;

  alu_seq #(.NBYTES(NBYTES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a_in      (a_in),
    .b_in      (b_in),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .c_out     (c_out)
`ifdef ALU_SEQ_FLAGS_EN
    ,
    .z_out     (z_out),
    .n_out     (n_out),
    .v_out     (v_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: whole-word arithmetic, returns {carry/borrow, result}.
  function automatic logic [W:0] ref_op(input op_seq_t o, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input logic c);
    longint unsigned ua, ub, s;
    ua = a;
    ub = b;
    case (o)
      SNOP:    return {c, a};
      SINC:    begin s = ua + 1;      return (W+1)'(s); end
      SADD:    begin s = ua + ub + c; return (W+1)'(s); end
      default: return {(ua < ub + c), W'(ua - ub - c)};
    endcase
  endfunction

`ifdef ALU_SEQ_FLAGS_EN
  // Reference flags {z, n, v}: v from the exact signed result leaving the W-bit range.
  function automatic logic [2:0] ref_flags(input op_seq_t o, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic c);
    logic [W:0] r;
    longint sa, sb, sr, maxv, minv;
    logic v;
    r    = ref_op(o, a, b, c);
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    maxv = (longint'(1) <<< (W - 1)) - 1;
    minv = -(longint'(1) <<< (W - 1));
    case (o)
      SINC:    sr = sa + 1;
      SADD:    sr = sa + sb + longint'(c);
      SSUB:    sr = sa - sb - longint'(c);
      default: sr = 0;
    endcase
    v = (o != SNOP) && ((sr > maxv) || (sr < minv));
    return {(r[W-1:0] == '0), r[W-1], v};
  endfunction
`endif

  // Issue one request, wait for the result, hold it `hold` cycles, then take it.
  // lat counts rising edges from the accepting edge (inclusive) to out_valid.
  task automatic run_op(input op_seq_t o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input int hold, output logic [W-1:0] r,
                        output logic co, output int lat, output logic ok);
    int n;
    n   = 0;
    ok  = 1'b1;
    lat = 0;
    r   = '0;
    co  = 1'b0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin ok = 1'b0; return; end
    op = o; a_in = a; b_in = b; c_in = c; in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    in_valid = 1'b0;
    op = op_seq_t'($urandom_range(0, 3));
    a_in = W'($urandom); b_in = W'($urandom); c_in = 1'($urandom);
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!out_valid) begin ok = 1'b0; return; end
    r  = result;
    co = c_out;
`ifdef ALU_SEQ_FLAGS_EN
    cap_flags = {z_out, n_out, v_out};
`endif
    repeat (hold) @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    tests++;
    if ({in_ready, out_valid, c_out, result} !== '0) begin
      fails++;
      $display("FAIL reset_values: got rdy=%b vld=%b c=%b res=%h, want all 0",
               in_ready, out_valid, c_out, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_ready_low: got %b want 0", in_ready);
    end
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_first_edge_ready: got %b want 1", in_ready);
    end
  endtask

  typedef struct {
    op_seq_t    o;
    logic [W-1:0] a, b;
    logic       c;
    logic [W-1:0] er;
    logic       ec;
  } vec_t;

  task automatic test_directed;
    vec_t v[5];
    logic [W-1:0] r;
    logic co, ok;
    int lat;
    v[0] = '{SADD, 16'h12FF, 16'h0001, 1'b0, 16'h1300, 1'b0};
    v[1] = '{SSUB, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1};
    v[2] = '{SSUB, 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0};
    v[3] = '{SINC, 16'hFFFF, 16'hAAAA, 1'b0, 16'h0000, 1'b1};
    v[4] = '{SNOP, 16'hBEEF, 16'h1234, 1'b1, 16'hBEEF, 1'b1};
    foreach (v[i]) begin
      run_op(v[i].o, v[i].a, v[i].b, v[i].c, 0, r, co, lat, ok);
      tests++;
      if (!ok || r !== v[i].er || co !== v[i].ec) begin
        fails++;
        $display("FAIL directed_%0d: got ok=%b res=%h c=%b, want res=%h c=%b",
                 i, ok, r, co, v[i].er, v[i].ec);
      end
      tests++;
      if (lat !== NBYTES + 1) begin
        fails++;
        $display("FAIL directed_latency_%0d: got %0d want %0d", i, lat, NBYTES + 1);
      end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, r;
    logic c, co, ok;
    logic [W:0] exp;
    op_seq_t o;
    int lat;
    for (int i = 0; i < 30; i++) begin
      o = op_seq_t'($urandom_range(0, 3));
      a = W'($urandom); b = W'($urandom); c = 1'($urandom);
      if (i % 7 == 0) a = '1;
      if (i % 5 == 0) b = a;
      exp = ref_op(o, a, b, c);
      run_op(o, a, b, c, $urandom_range(0, 3), r, co, lat, ok);
      tests++;
      if (!ok || {co, r} !== exp || lat !== NBYTES + 1) begin
        fails++;
        $display("FAIL random_%0d op=%0d a=%h b=%h c=%b: got ok=%b c=%b res=%h lat=%0d, want c=%b res=%h lat=%0d",
                 i, o, a, b, c, ok, co, r, lat, exp[W], exp[W-1:0], NBYTES + 1);
      end
`ifdef ALU_SEQ_FLAGS_EN
      tests++;
      if (cap_flags !== ref_flags(o, a, b, c)) begin
        fails++;
        $display("FAIL random_flags_%0d: got znv=%b want %b", i, cap_flags, ref_flags(o, a, b, c));
      end
`endif
    end
  endtask

  task automatic test_backpressure;
    logic [W-1:0] a1, b1, a2, b2;
    logic [W:0] e1, e2;
    int n;
    a1 = W'($urandom); b1 = W'($urandom);
    a2 = W'($urandom); b2 = W'($urandom);
    e1 = ref_op(SADD, a1, b1, 1'b1);
    e2 = ref_op(SSUB, a2, b2, 1'b0);
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    op = SADD; a_in = a1; b_in = b1; c_in = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    // Second request held while the first is busy.
    op = SSUB; a_in = a2; b_in = b2; c_in = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    for (int k = 0; k < 5; k++) begin
      tests++;
      if ({out_valid, in_ready, c_out, result} !== {1'b1, 1'b0, e1}) begin
        fails++;
        $display("FAIL backpressure_hold_%0d: got vld=%b rdy=%b c=%b res=%h, want vld=1 rdy=0 c=%b res=%h",
                 k, out_valid, in_ready, c_out, result, e1[W], e1[W-1:0]);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++;
    if ({in_ready, out_valid} !== 2'b10) begin
      fails++;
      $display("FAIL backpressure_release: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL backpressure_second_accept: rdy got %b want 0", in_ready);
    end
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    tests++;
    if ({out_valid, c_out, result} !== {1'b1, e2}) begin
      fails++;
      $display("FAIL backpressure_second_result: got vld=%b c=%b res=%h want c=%b res=%h",
               out_valid, c_out, result, e2[W], e2[W-1:0]);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [W:0] q[$];
    logic [W:0] e;
    int prev, accepts, cyc;
    logic pend;
    prev = -1; accepts = 0; cyc = 0; pend = 1'b0;
    out_ready = 1'b1;
    op = op_seq_t'($urandom_range(0, 3));
    a_in = W'($urandom); b_in = W'($urandom); c_in = 1'($urandom);
    in_valid = 1'b1;
    while (accepts < 6 && cyc < 200) begin
      if (out_valid) begin
        e = q.pop_front();
        tests++;
        if ({c_out, result} !== e) begin
          fails++;
          $display("FAIL b2b_result: got c=%b res=%h want c=%b res=%h", c_out, result, e[W], e[W-1:0]);
        end
      end
      if (in_ready) begin
        q.push_back(ref_op(op, a_in, b_in, c_in));
        if (prev >= 0) begin
          tests++;
          if (cyc - prev !== NBYTES + 2) begin
            fails++;
            $display("FAIL b2b_interval: got %0d want %0d", cyc - prev, NBYTES + 2);
          end
        end
        prev = cyc;
        accepts++;
        pend = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
      if (pend) begin
        pend = 1'b0;
        op = op_seq_t'($urandom_range(0, 3));
        a_in = W'($urandom); b_in = W'($urandom); c_in = 1'($urandom);
      end
    end
    in_valid = 1'b0;
    cyc = 0;
    while (q.size() > 0 && cyc < 50) begin
      if (out_valid) begin
        e = q.pop_front();
        tests++;
        if ({c_out, result} !== e) begin
          fails++;
          $display("FAIL b2b_drain: got c=%b res=%h want c=%b res=%h", c_out, result, e[W], e[W-1:0]);
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    tests++;
    if (q.size() !== 0 || accepts !== 6) begin
      fails++;
      $display("FAIL b2b_count: accepts=%0d pending=%0d want 6 and 0", accepts, q.size());
    end
    out_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run;
    logic [W-1:0] a, b, r;
    logic co, ok;
    logic [W:0] exp;
    int lat, n;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    op = SADD; a_in = 16'h1234; b_in = 16'h0101; c_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({in_ready, out_valid, c_out, result} !== '0) begin
      fails++;
      $display("FAIL reset_mid_run: got rdy=%b vld=%b c=%b res=%h want all 0",
               in_ready, out_valid, c_out, result);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_run_ready: got %b want 1", in_ready);
    end
    a = W'($urandom); b = W'($urandom);
    exp = ref_op(SSUB, a, b, 1'b1);
    run_op(SSUB, a, b, 1'b1, 1, r, co, lat, ok);
    tests++;
    if (!ok || {co, r} !== exp) begin
      fails++;
      $display("FAIL reset_mid_run_next_op: got ok=%b c=%b res=%h want c=%b res=%h",
               ok, co, r, exp[W], exp[W-1:0]);
    end
  endtask

`ifdef ALU_SEQ_FLAGS_EN
  task automatic test_flags;
    logic [W-1:0] r;
    logic co, ok;
    int lat;
    run_op(SADD, 16'h7FFF, 16'h0001, 1'b0, 0, r, co, lat, ok);
    tests++;
    if (!ok || r !== 16'h8000 || cap_flags !== 3'b011) begin
      fails++;
      $display("FAIL flags_add_overflow: got res=%h znv=%b want res=8000 znv=011", r, cap_flags);
    end
    run_op(SSUB, 16'h0005, 16'h0005, 1'b0, 0, r, co, lat, ok);
    tests++;
    if (!ok || r !== '0 || co !== 1'b0 || cap_flags !== 3'b100) begin
      fails++;
      $display("FAIL flags_sub_zero: got res=%h c=%b znv=%b want res=0000 c=0 znv=100", r, co, cap_flags);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = SNOP; a_in = '0; b_in = '0; c_in = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
`ifdef ALU_SEQ_FLAGS_EN
    test_flags();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
